// File: rtl/fp_add_result_q.sv
// Result-side companion to the two-cycle FP adder: carries destination tags alongside the adder,
// buffers tagged results in a small FIFO for a stallable writeback port, and issues start credits.
module fp_add_result_q #(
   parameter int RV    = 64,
   parameter int TAG   = 6,
   parameter int LAT   = 2,
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           flush,
   input  logic           start,
   input  logic [TAG-1:0] start_tag,
   output logic           issue_ready,
   input  logic           add_valid,
   input  logic           add_exception,
   input  logic [RV-1:0]  add_res,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [TAG-1:0] out_tag,
   output logic [RV-1:0]  out_res,
   output logic [4:0]     out_fflags,
   output logic           err
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = $clog2(LAT + DEPTH + 1) + 1;
   localparam int SW = $clog2(LAT + 1);

   typedef struct packed {
      logic [TAG-1:0] tag;
      logic [RV-1:0]  res;
      logic           exc;
   } entry_t;

   logic [LAT-1:0]           v_pipe;
   logic [LAT-1:0][TAG-1:0]  tag_pipe;
   logic [SW-1:0]            shadow;
   entry_t                   mem [DEPTH];
   entry_t                   head;
   logic [PW-1:0]            wr_ptr, rd_ptr, occ;
   logic [CW-1:0]            inflight, load;
   logic                     full, empty, v_last, suppress;
   logic                     push_req, push, pop, err_set;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < LAT; i++) inflight = inflight + CW'(v_pipe[i]);
   end

   assign occ         = wr_ptr - rd_ptr;
   assign load        = inflight + CW'(occ);
   assign issue_ready = load < CW'(DEPTH);

   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign v_last = v_pipe[LAT-1];

   // A pop frees the slot in the same cycle, so a full FIFO still accepts a push while draining.
   assign push_req = add_valid && v_last && !flush;
   assign pop      = !empty && out_ready && !flush;
   assign push     = push_req && (!full || pop);

   // Results of ops killed by a flush are still emitted by the adder for LAT cycles afterwards.
   assign suppress = flush || (shadow != '0);
   assign err_set  = (start && !issue_ready)
                   || (push_req && full && !pop)
                   || (!suppress && add_valid && !v_last)
                   || (!suppress && v_last && !add_valid);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v_pipe   <= '0;
         tag_pipe <= '0;
      end else begin
         tag_pipe[0] <= start_tag;
         for (int i = 1; i < LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
         if (flush) begin
            v_pipe <= '0;
         end else begin
            v_pipe[0] <= start;
            for (int i = 1; i < LAT; i++) v_pipe[i] <= v_pipe[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)               shadow <= '0;
      else if (flush)          shadow <= SW'(LAT);
      else if (shadow != '0)   shadow <= shadow - 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= '{tag: tag_pipe[LAT-1], res: add_res, exc: add_exception};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        err <= 1'b0;
      else if (err_set) err <= 1'b1;
   end

   assign head       = mem[rd_ptr[AW-1:0]];
   assign out_valid  = !empty;
   assign out_tag    = head.tag;
   assign out_res    = head.res;
   assign out_fflags = {head.exc, 4'b0000};

endmodule
